bus_dma_master: RTL and testbench

Bus initiator that copies a block of 32-bit words from one slave address range to another through the two-master/two-slave shared bus. It sits on either master port of `bus`:

- It raises a request and waits for the arbiter's grant.
- It then alternates read and write transfers until the programmed word count is exhausted, and pulses `done`.

It is the active end of the master-side bus interface and replaces hand-driven master stimulus in system benches.

---
 rtl/bus_dma_master.sv | 120 ++++++++++++
 tb/tb_bus_dma_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_master.sv
// Bus-master block copier: requests the shared bus, then moves op_len words
// from op_src to op_dst as RD / RD_WAIT / WR triplets and pulses done.
module bus_dma_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic [ADDR_W-1:0] op_src,
    input  logic [ADDR_W-1:0] op_dst,
    input  logic [7:0]        op_len,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, REQ, RD, RD_WAIT, WR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [7:0]        remain;
    logic [DATA_W-1:0] data_buf;

    assign m_dout = data_buf;

    // Outputs are registered together with the transition that enters each
    // state, so they always match the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remain    <= '0;
            data_buf  <= '0;
            m_req     <= 1'b0;
            m_wr      <= 1'b0;
            m_address <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        src_ptr <= op_src;
                        dst_ptr <= op_dst;
                        remain  <= op_len;
                        busy    <= 1'b1;
                        if (op_len != 8'd0) begin
                            state <= REQ;
                            m_req <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (m_grant) begin
                        state     <= RD;
                        m_address <= src_ptr;
                    end
                end
                RD: begin
                    if (!m_grant) begin
                        state     <= REQ;
                        m_address <= '0;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!m_grant) begin
                        state     <= REQ;
                        m_address <= '0;
                    end else begin
                        data_buf  <= m_din;
                        state     <= WR;
                        m_wr      <= 1'b1;
                        m_address <= dst_ptr;
                    end
                end
                WR: begin
                    m_wr <= 1'b0;
                    if (!m_grant) begin
                        // Word not committed: pointers stay, word restarts.
                        state     <= REQ;
                        m_address <= '0;
                    end else begin
                        src_ptr <= src_ptr + 1'b1;
                        dst_ptr <= dst_ptr + 1'b1;
                        remain  <= remain - 8'd1;
                        if (remain != 8'd1) begin
                            state     <= RD;
                            m_address <= src_ptr + 1'b1;
                        end else begin
                            state     <= DONE;
                            m_req     <= 1'b0;
                            done      <= 1'b1;
                            m_address <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a registered-grant arbiter and a
// registered-read memory standing in for the shared bus and its slaves.
module tb_bus_dma_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start = 1'b0;
    logic [7:0]  op_src = '0, op_dst = '0, op_len = '0;
    logic [31:0] m_din;
    logic        grant_q = 1'b0, drop = 1'b0, hold = 1'b0;
    wire         m_grant = grant_q & ~drop;
    logic        m_req, m_wr, busy, done;
    logic [7:0]  m_address;
    logic [31:0] m_dout;

    logic [31:0] mem [256];
    logic [7:0]  wa [$];
    logic [31:0] wd [$];
    int cyc = 0, e0 = 0, ndone = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    bus_dma_master #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_src(op_src),
        .op_dst(op_dst), .op_len(op_len), .m_grant(m_grant), .m_din(m_din),
        .m_req(m_req), .m_wr(m_wr), .m_address(m_address), .m_dout(m_dout),
        .busy(busy), .done(done)
    );

    // Bus model: arbiter registers grant, slaves register read data.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        grant_q <= m_req & ~hold;
        m_din   <= mem[m_address];
        if (m_req && m_wr && m_grant) begin
            mem[m_address] <= m_dout;
            wa.push_back(m_address);
            wd.push_back(m_dout);
        end
    end

    always @(negedge clk) if (done) ndone++;

    task automatic start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        @(posedge clk); #1;
        op_src = s; op_dst = d; op_len = n; op_start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        op_start = 1'b0;
    endtask

    // Advance to the negedge inside spec cycle n (cycle 1 follows the start edge).
    task automatic to_cycle(input int n);
        do @(negedge clk); while (cyc - e0 + 1 < n);
    endtask

    task automatic wait_done(input int bound, output int lat, output int gaps);
        lat = -1; gaps = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin lat = cyc - e0 + 1; return; end
            if (!m_req) gaps++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; op_start = 1'b1; op_len = 8'd3;
        #12;
        checks++;
        if ({m_req, m_wr, busy, done, m_address, m_dout} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b wr=%b busy=%b done=%b addr=%h dout=%h exp all 0",
                     m_req, m_wr, busy, done, m_address, m_dout);
        end
        op_start = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, m_req, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got busy=%b req=%b done=%b exp 000", busy, m_req, done);
        end
    endtask

    task automatic test_single;
        int nw0;
        mem[8'h00] = 32'hDEADDEAD; mem[8'h20] = 32'h0;
        nw0 = wa.size();
        start(8'h00, 8'h20, 8'd1);
        to_cycle(1);
        checks++;
        if ({busy, m_req} !== 2'b11) begin
            errors++; $display("FAIL single_c1 got busy=%b req=%b exp 11", busy, m_req);
        end
        to_cycle(3);
        checks++;
        if ({m_req, m_wr, m_address} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL single_rd got req=%b wr=%b addr=%h exp 1 0 00", m_req, m_wr, m_address);
        end
        to_cycle(5);
        checks++;
        if ({m_wr, m_address, m_dout} !== {1'b1, 8'h20, 32'hDEADDEAD}) begin
            errors++; $display("FAIL single_wr got wr=%b addr=%h dout=%h exp 1 20 deaddead", m_wr, m_address, m_dout);
        end
        to_cycle(6);
        checks++;
        if ({done, m_req} !== 2'b10) begin
            errors++; $display("FAIL single_done got done=%b req=%b exp 10", done, m_req);
        end
        checks++;
        if (mem[8'h20] !== 32'hDEADDEAD || wa.size() - nw0 != 1) begin
            errors++; $display("FAIL single_mem got %h writes=%0d exp deaddead 1", mem[8'h20], wa.size() - nw0);
        end
    endtask

    task automatic test_four;
        logic [31:0] ev [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        int lat, gaps;
        for (int i = 0; i < 4; i++) begin mem[i] = ev[i]; mem[8'h20 + i] = 32'h0; end
        start(8'h00, 8'h20, 8'd4);
        wait_done(40, lat, gaps);
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL four_lat got %0d exp 15", lat); end
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL four_req_gaps got %0d exp 0", gaps); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[8'h20 + i] !== ev[i]) begin
                errors++; $display("FAIL four_mem[%0d] got %h exp %h", i, mem[8'h20 + i], ev[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL four_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_ignore_start;
        int lat, gaps, nd0, nw0;
        mem[8'h05] = 32'hCAFE0005; mem[8'h06] = 32'hCAFE0006;
        mem[8'h30] = 32'h0; mem[8'h31] = 32'h0; mem[8'h60] = 32'h0;
        nd0 = ndone; nw0 = wa.size();
        start(8'h05, 8'h30, 8'd2);
        to_cycle(4);
        op_src = 8'h50; op_dst = 8'h60; op_len = 8'd9; op_start = 1'b1;
        @(posedge clk); #1; op_start = 1'b0;
        wait_done(40, lat, gaps);
        repeat (4) @(negedge clk);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL ignore_lat got %0d exp 9", lat); end
        checks++;
        if (ndone - nd0 !== 1 || wa.size() - nw0 != 2) begin
            errors++; $display("FAIL ignore_count got done=%0d writes=%0d exp 1 2", ndone - nd0, wa.size() - nw0);
        end
        checks++;
        if (mem[8'h30] !== 32'hCAFE0005 || mem[8'h31] !== 32'hCAFE0006 || mem[8'h60] !== 32'h0) begin
            errors++; $display("FAIL ignore_mem got %h %h %h exp cafe0005 cafe0006 0", mem[8'h30], mem[8'h31], mem[8'h60]);
        end
    endtask

    task automatic test_contention;
        int lat, gaps, nw0;
        mem[8'h08] = 32'hA0A00008; mem[8'h09] = 32'hA0A00009;
        mem[8'h28] = 32'h0; mem[8'h29] = 32'h0;
        nw0 = wa.size();
        hold = 1'b1;
        start(8'h08, 8'h28, 8'd2);
        for (int c = 1; c <= 6; c++) begin
            to_cycle(c);
            checks++;
            if (m_req !== 1'b1 || m_wr !== 1'b0 || wa.size() != nw0) begin
                errors++; $display("FAIL hold_c%0d got req=%b wr=%b writes=%0d exp 1 0 0", c, m_req, m_wr, wa.size() - nw0);
            end
        end
        hold = 1'b0;
        wait_done(40, lat, gaps);
        checks++;
        if (lat !== 14) begin errors++; $display("FAIL hold_lat got %0d exp 14", lat); end
        checks++;
        if (mem[8'h28] !== 32'hA0A00008 || mem[8'h29] !== 32'hA0A00009) begin
            errors++; $display("FAIL hold_mem got %h %h exp a0a00008 a0a00009", mem[8'h28], mem[8'h29]);
        end
    endtask

    task automatic test_grant_loss;
        int lat, gaps, nw0;
        for (int i = 0; i < 4; i++) begin mem[8'h10 + i] = 32'hB0000010 + i; mem[8'h38 + i] = 32'h0; end
        nw0 = wa.size();
        start(8'h10, 8'h38, 8'd4);
        to_cycle(7);
        drop = 1'b1;
        @(posedge clk); #1; drop = 1'b0;
        to_cycle(8);
        checks++;
        if ({m_req, m_wr, m_address} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL loss_req got req=%b wr=%b addr=%h exp 1 0 00", m_req, m_wr, m_address);
        end
        wait_done(60, lat, gaps);
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL loss_lat got %0d exp 18", lat); end
        checks++;
        if (wa.size() - nw0 != 4) begin errors++; $display("FAIL loss_writes got %0d exp 4", wa.size() - nw0); end
        for (int i = 0; i < 4 && nw0 + i < wa.size(); i++) begin
            checks++;
            if (wa[nw0 + i] !== 8'h38 + i || wd[nw0 + i] !== 32'hB0000010 + i) begin
                errors++; $display("FAIL loss_wr%0d got addr=%h data=%h exp %h %h", i, wa[nw0 + i], wd[nw0 + i],
                                   8'h38 + i, 32'hB0000010 + i);
            end
        end
    endtask

    task automatic test_wrap;
        int lat, gaps;
        mem[8'hFE] = 32'hA1A1A1A1; mem[8'hFF] = 32'hB2B2B2B2; mem[8'h00] = 32'hC3C3C3C3;
        mem[8'h40] = 32'h0; mem[8'h41] = 32'h0; mem[8'h42] = 32'h0;
        start(8'hFE, 8'h40, 8'd3);
        wait_done(40, lat, gaps);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL wrap_lat got %0d exp 12", lat); end
        checks++;
        if (mem[8'h40] !== 32'hA1A1A1A1 || mem[8'h41] !== 32'hB2B2B2B2 || mem[8'h42] !== 32'hC3C3C3C3) begin
            errors++; $display("FAIL wrap_mem got %h %h %h exp a1a1a1a1 b2b2b2b2 c3c3c3c3",
                               mem[8'h40], mem[8'h41], mem[8'h42]);
        end
    endtask

    task automatic test_zero;
        int nw0;
        nw0 = wa.size();
        start(8'h00, 8'h44, 8'd0);
        to_cycle(1);
        checks++;
        if ({done, m_req, busy} !== 3'b101) begin
            errors++; $display("FAIL zero_c1 got done=%b req=%b busy=%b exp 1 0 1", done, m_req, busy);
        end
        to_cycle(2);
        checks++;
        if ({done, m_req, busy} !== 3'b000 || wa.size() != nw0) begin
            errors++; $display("FAIL zero_c2 got done=%b req=%b busy=%b writes=%0d exp 0 0 0 0",
                               done, m_req, busy, wa.size() - nw0);
        end
    endtask

    task automatic test_reset_mid;
        int lat, gaps, nd0;
        for (int i = 0; i < 4; i++) begin mem[i] = 32'hD0000000 + i; mem[8'h48 + i] = 32'h0; end
        mem[8'h4C] = 32'h0;
        nd0 = ndone;
        start(8'h00, 8'h48, 8'd4);
        to_cycle(8);
        checks++;
        if ({m_wr, m_address} !== {1'b1, 8'h49}) begin
            errors++; $display("FAIL mid_wr got wr=%b addr=%h exp 1 49", m_wr, m_address);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({m_req, m_wr, busy, done, m_address, m_dout} !== 44'd0) begin
            errors++; $display("FAIL mid_clear got req=%b wr=%b busy=%b done=%b addr=%h dout=%h exp all 0",
                               m_req, m_wr, busy, done, m_address, m_dout);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ndone !== nd0 || mem[8'h48] !== 32'hD0000000 || mem[8'h49] !== 32'h0) begin
            errors++; $display("FAIL mid_abort got dones=%0d m48=%h m49=%h exp 0 d0000000 0",
                               ndone - nd0, mem[8'h48], mem[8'h49]);
        end
        start(8'h02, 8'h4C, 8'd1);
        wait_done(40, lat, gaps);
        checks++;
        if (lat !== 6 || mem[8'h4C] !== 32'hD0000002) begin
            errors++; $display("FAIL mid_restart got lat=%0d data=%h exp 6 d0000002", lat, mem[8'h4C]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset;
        test_single;
        test_four;
        test_ignore_start;
        test_contention;
        test_grant_loss;
        test_wrap;
        test_zero;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
